// File: rtl/circuito_exp5.sv
// Memory game (Genius/Simon): 16 progressive rounds against a fixed 4-bit sequence ROM.
// Optional per-move timeout enabled by defining TIMEOUT_EN; default build waits forever in espera.
module circuito_exp5 #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int N_ROUNDS       = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic [3:0] botoes,
    output logic       ganhou,
    output logic       perdeu,
    output logic       pronto,
    output logic [3:0] leds,
    output logic       db_igual,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic [6:0] db_sequencia,
    output logic       db_clock,
    output logic       db_iniciar,
    output logic       db_fimseq,
    output logic       db_igualseq,
    output logic       db_igualjogada,
    output logic       db_tem_jogada,
    output logic       db_timeout
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIA_RODADA  = 4'h2,
        ESPERA         = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTOU    = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERROU      = 4'hE
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(N_ROUNDS - 1);

    if (N_ROUNDS < 1 || N_ROUNDS > 16 || TIMEOUT_CYCLES < 2) begin : g_cfg_err
        $error("circuito_exp5: unsupported parameter set");
    end

`ifdef TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q;
    logic          timeout_q;
`endif

    state_t     state_q;
    logic [3:0] addr_q;
    logic [3:0] round_q;
    logic [3:0] jogada_q;
    logic       botao_prev_q;
    logic       tem_jogada_q;
    logic       ganhou_q;
    logic       perdeu_q;
    logic       pronto_q;

    function automatic logic [3:0] rom_data(input logic [3:0] a);
        case (a)
            4'h0: rom_data = 4'h1;  4'h1: rom_data = 4'h2;
            4'h2: rom_data = 4'h4;  4'h3: rom_data = 4'h8;
            4'h4: rom_data = 4'h4;  4'h5: rom_data = 4'h2;
            4'h6: rom_data = 4'h1;  4'h7: rom_data = 4'h1;
            4'h8: rom_data = 4'h2;  4'h9: rom_data = 4'h2;
            4'hA: rom_data = 4'h4;  4'hB: rom_data = 4'h4;
            4'hC: rom_data = 4'h8;  4'hD: rom_data = 4'h8;
            4'hE: rom_data = 4'h1;  default: rom_data = 4'h4;
        endcase
    endfunction

    // Segments gfedcba, active-low.
    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        case (v)
            4'h0: hex7seg = 7'h40;  4'h1: hex7seg = 7'h79;
            4'h2: hex7seg = 7'h24;  4'h3: hex7seg = 7'h30;
            4'h4: hex7seg = 7'h19;  4'h5: hex7seg = 7'h12;
            4'h6: hex7seg = 7'h02;  4'h7: hex7seg = 7'h78;
            4'h8: hex7seg = 7'h00;  4'h9: hex7seg = 7'h10;
            4'hA: hex7seg = 7'h08;  4'hB: hex7seg = 7'h03;
            4'hC: hex7seg = 7'h46;  4'hD: hex7seg = 7'h21;
            4'hE: hex7seg = 7'h06;  default: hex7seg = 7'h0E;
        endcase
    endfunction

    // NOTE: every register below updates with <= so all reads in this block see pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= INICIAL;
            addr_q       <= '0;
            round_q      <= '0;
            jogada_q     <= '0;
            botao_prev_q <= 1'b0;
            tem_jogada_q <= 1'b0;
            ganhou_q     <= 1'b0;
            perdeu_q     <= 1'b0;
            pronto_q     <= 1'b0;
`ifdef TIMEOUT_EN
            tmo_q        <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            botao_prev_q <= |botoes;
            tem_jogada_q <= (|botoes) & ~botao_prev_q;

            case (state_q)
                INICIAL: if (jogar) state_q <= PREPARACAO;
                PREPARACAO: begin
                    round_q <= '0;
                    state_q <= INICIA_RODADA;
                end
                INICIA_RODADA: begin
                    addr_q  <= '0;
`ifdef TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                    state_q <= ESPERA;
                end
                ESPERA: begin
`ifdef TIMEOUT_EN
                    if (tmo_q != TMO_MAX) tmo_q <= tmo_q + TW'(1);
                    // A move detected on the timeout cycle takes priority.
                    if (tem_jogada_q) begin
                        state_q <= REGISTRA;
                    end else if (tmo_q == TMO_MAX) begin
                        state_q   <= FIM_TIMEOUT;
                        perdeu_q  <= 1'b1;
                        pronto_q  <= 1'b1;
                        timeout_q <= 1'b1;
                    end
`else
                    if (tem_jogada_q) state_q <= REGISTRA;
`endif
                end
                REGISTRA: begin
                    jogada_q <= botoes;
                    state_q  <= COMPARACAO;
                end
                COMPARACAO: begin
                    if (jogada_q != rom_data(addr_q)) begin
                        state_q  <= FIM_ERROU;
                        perdeu_q <= 1'b1;
                        pronto_q <= 1'b1;
                    end else if (addr_q == round_q) begin
                        if (round_q == LAST_ROUND) begin
                            state_q  <= FIM_ACERTOU;
                            ganhou_q <= 1'b1;
                            pronto_q <= 1'b1;
                        end else begin
                            state_q <= PROXIMA_RODADA;
                        end
                    end else begin
                        state_q <= PROXIMA_JOGADA;
                    end
                end
                PROXIMA_JOGADA: begin
                    addr_q  <= addr_q + 4'd1;
`ifdef TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                    state_q <= ESPERA;
                end
                PROXIMA_RODADA: begin
                    round_q <= round_q + 4'd1;
                    state_q <= INICIA_RODADA;
                end
                FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
                    if (jogar) begin
                        state_q   <= PREPARACAO;
                        ganhou_q  <= 1'b0;
                        perdeu_q  <= 1'b0;
                        pronto_q  <= 1'b0;
`ifdef TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q   <= INICIAL;
                    ganhou_q  <= 1'b0;
                    perdeu_q  <= 1'b0;
                    pronto_q  <= 1'b0;
`ifdef TIMEOUT_EN
                    timeout_q <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign ganhou         = ganhou_q;
    assign perdeu         = perdeu_q;
    assign pronto         = pronto_q;
    assign leds           = (state_q == ESPERA) ? botoes : 4'b0000;
    assign db_igual       = (jogada_q == rom_data(addr_q));
    assign db_igualjogada = db_igual;
    assign db_contagem    = hex7seg(addr_q);
    assign db_memoria     = hex7seg(rom_data(addr_q));
    assign db_estado      = hex7seg(state_q);
    assign db_jogadafeita = hex7seg(jogada_q);
    assign db_sequencia   = hex7seg(round_q);
    assign db_clock       = clock;
    assign db_iniciar     = jogar;
    assign db_fimseq      = (round_q == LAST_ROUND);
    assign db_igualseq    = (addr_q == round_q);
    assign db_tem_jogada  = tem_jogada_q;
`ifdef TIMEOUT_EN
    assign db_timeout     = timeout_q;
`else
    assign db_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_circuito_exp5.sv
// Directed-vector bench for circuito_exp5; expectations follow the TIMEOUT_EN setting of the build.
module tb_circuito_exp5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       jogar = 1'b0;
    logic [3:0] botoes = 4'b0000;
    logic       ganhou, perdeu, pronto, db_igual, db_clock, db_iniciar;
    logic       db_fimseq, db_igualseq, db_igualjogada, db_tem_jogada, db_timeout;
    logic [3:0] leds;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_sequencia;

    int n_vec = 0;
    int n_err = 0;

    // Active-low gfedcba patterns, written out by hand.
    localparam logic [6:0] SEG_0 = 7'h40, SEG_1 = 7'h79, SEG_2 = 7'h24, SEG_3 = 7'h30;
    localparam logic [6:0] SEG_5 = 7'h12, SEG_A = 7'h08, SEG_D = 7'h21, SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    logic [3:0] seq_exp [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                                 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

    circuito_exp5 dut (
        .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
        .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .leds(leds),
        .db_igual(db_igual), .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_estado(db_estado), .db_jogadafeita(db_jogadafeita), .db_sequencia(db_sequencia),
        .db_clock(db_clock), .db_iniciar(db_iniciar), .db_fimseq(db_fimseq),
        .db_igualseq(db_igualseq), .db_igualjogada(db_igualjogada),
        .db_tem_jogada(db_tem_jogada), .db_timeout(db_timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] v);
        @(negedge clock) botoes = v;
        repeat (10) @(negedge clock);
        botoes = 4'b0000;
        repeat (10) @(negedge clock);
    endtask

    task automatic start_game();
        @(negedge clock) jogar = 1'b1;
        repeat (5) @(negedge clock);
        jogar = 1'b0;
    endtask

    int pulses;
    int compares;

    initial begin
        #12 reset = 1'b1;
        repeat (15) @(negedge clock);
        check("idle_estado", 32'(db_estado), 32'(SEG_0));
        check("idle_ganhou", 32'(ganhou), 0);
        check("idle_perdeu", 32'(perdeu), 0);
        check("idle_pronto", 32'(pronto), 0);
        check("idle_leds",   32'(leds), 0);

        // Full winning game.
        @(negedge clock) jogar = 1'b1;
        #1 check("db_iniciar", 32'(db_iniciar), 1);
        repeat (5) @(negedge clock);
        jogar = 1'b0;
        check("start_estado", 32'(db_estado), 32'(SEG_3));
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i <= r; i++) press(seq_exp[i]);
            if (r == 0) check("round1_seq", 32'(db_sequencia), 32'(SEG_1));
        end
        check("win_estado",  32'(db_estado), 32'(SEG_A));
        check("win_ganhou",  32'(ganhou), 1);
        check("win_pronto",  32'(pronto), 1);
        check("win_perdeu",  32'(perdeu), 0);
        check("win_seq",     32'(db_sequencia), 32'(SEG_F));
        check("win_cont",    32'(db_contagem), 32'(SEG_F));
        check("win_fimseq",  32'(db_fimseq), 1);
        check("win_igualseq", 32'(db_igualseq), 1);

        // Restart, clear round 0, then go silent.
        start_game();
        check("restart_ganhou", 32'(ganhou), 0);
        press(4'b0001);
        check("tmo_round1", 32'(db_sequencia), 32'(SEG_1));
        repeat (4000) @(negedge clock);
        check("tmo_early_estado", 32'(db_estado), 32'(SEG_3));
        repeat (6000) @(negedge clock);
`ifdef TIMEOUT_EN
        check("tmo_estado",  32'(db_estado), 32'(SEG_D));
        check("tmo_perdeu",  32'(perdeu), 1);
        check("tmo_pronto",  32'(pronto), 1);
        check("tmo_flag",    32'(db_timeout), 1);
`else
        check("notmo_estado", 32'(db_estado), 32'(SEG_3));
        check("notmo_perdeu", 32'(perdeu), 0);
        check("notmo_pronto", 32'(pronto), 0);
        check("notmo_flag",   32'(db_timeout), 0);
        // Leave espera through a wrong move so the next start finds an end state.
        press(4'b1000);
`endif

        // Wrong first move.
        start_game();
        @(negedge clock) botoes = 4'b0010;
        #1 check("leds_echo", 32'(leds), 32'h2);
        repeat (10) @(negedge clock);
        botoes = 4'b0000;
        repeat (10) @(negedge clock);
        check("err_estado",  32'(db_estado), 32'(SEG_E));
        check("err_perdeu",  32'(perdeu), 1);
        check("err_pronto",  32'(pronto), 1);
        check("err_ganhou",  32'(ganhou), 0);
        check("err_igual",   32'(db_igual), 0);
        check("err_jogada",  32'(db_jogadafeita), 32'(SEG_2));
        check("err_flag",    32'(db_timeout), 0);
        check("err_leds",    32'(leds), 0);

        // Long hold gives one pulse and one comparison.
        start_game();
        pulses = 0;
        compares = 0;
        @(negedge clock) botoes = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (db_tem_jogada) pulses++;
            if (db_estado == SEG_5) compares++;
        end
        botoes = 4'b0000;
        repeat (5) @(negedge clock);
        check("hold_pulses",   32'(pulses), 1);
        check("hold_compares", 32'(compares), 1);
        check("hold_estado",   32'(db_estado), 32'(SEG_3));
        check("hold_seq",      32'(db_sequencia), 32'(SEG_1));
        check("hold_igual",    32'(db_igualjogada), 1);

        // Asynchronous reset in espera, sampled before the next rising edge.
        @(negedge clock);
        #1 reset = 1'b0;
        #1;
        check("rst_estado",  32'(db_estado), 32'(SEG_0));
        check("rst_cont",    32'(db_contagem), 32'(SEG_0));
        check("rst_seq",     32'(db_sequencia), 32'(SEG_0));
        check("rst_jogada",  32'(db_jogadafeita), 32'(SEG_0));
        check("rst_pronto",  32'(pronto), 0);
        check("rst_tem",     32'(db_tem_jogada), 0);
        @(negedge clock) reset = 1'b1;
        repeat (3) @(negedge clock);
        check("post_rst_estado", 32'(db_estado), 32'(SEG_0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/circuito_exp5.md
Name: circuito_exp5

Overview:
- Top level of a memory game (Genius/Simon style).
- Plays 16 progressive rounds against a fixed 16-entry 4-bit sequence ROM. Round r requires the player to repeat entries 0..r on four one-hot buttons.
- A per-move timeout ends the game.
- Exposes game-status outputs plus 7-segment and single-bit debug outputs for the FPGA board.

Parameters:
- TIMEOUT_CYCLES, 5000, clock cycles allowed per move (5 s at 1 kHz).
- N_ROUNDS, 16, number of rounds and ROM depth.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- jogar  in  1  start/restart request, level.
- botoes  in  4  player buttons, one-hot when pressed, 0000 when released.
- ganhou  out  1  game won.
- perdeu  out  1  game lost (wrong move or timeout).
- pronto  out  1  game finished.
- leds  out  4  echoes botoes while waiting for a move, else 0000.
- db_igual  out  1  registered move equals ROM[address].
- db_contagem  out  7  address counter, hex 7-seg.
- db_memoria  out  7  ROM[address], hex 7-seg.
- db_estado  out  7  FSM state code, hex 7-seg.
- db_jogadafeita  out  7  registered move, hex 7-seg.
- db_sequencia  out  7  round counter, hex 7-seg.
- db_clock  out  1  equals clock.
- db_iniciar  out  1  equals jogar.
- db_fimseq  out  1  round counter equals N_ROUNDS-1.
- db_igualseq  out  1  address equals round counter.
- db_igualjogada  out  1  same as db_igual.
- db_tem_jogada  out  1  one-cycle move-detected pulse.
- db_timeout  out  1  timeout flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to inicial.
  - Address, round, timeout counters and move register cleared.
  - Edge-detector history cleared.
  - All status outputs 0.
- 7-seg encoding: hex 0-F, segments gfedcba, active-low. Nibble values are zero-extended.
- ROM contents, addresses 0..15: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4 (hex).
- tem_jogada: registered rising-edge detect of OR(botoes). Exactly one pulse per press, regardless of hold length.
- FSM states (db_estado code):
  - inicial (0): wait; jogar=1 -> preparacao.
  - preparacao (1): clear round counter -> inicia_rodada.
  - inicia_rodada (2): clear address counter, clear timeout counter -> espera.
  - espera (3):
    - timeout counter increments each cycle.
    - tem_jogada -> registra.
    - If the counter reaches TIMEOUT_CYCLES-1 without a move -> fim_timeout.
    - A move on the same cycle as the timeout wins: go to registra.
  - registra (4): load botoes into move register -> comparacao.
  - comparacao (5), decisions in this order:
    - move != ROM[address] -> fim_errou.
    - else address == round:
      - round == N_ROUNDS-1 -> fim_acertou.
      - else -> proxima_rodada.
    - else -> proxima_jogada.
  - proxima_jogada (6): address+1, clear timeout counter -> espera.
  - proxima_rodada (7): round+1 -> inicia_rodada.
  - fim_acertou (A): ganhou=1, pronto=1.
  - fim_errou (E): perdeu=1, pronto=1.
  - fim_timeout (D): perdeu=1, pronto=1, db_timeout=1.
  - All end states: jogar=1 -> preparacao; outputs held until then.
  - Unused codes -> inicial.
- Output timing: ganhou, perdeu and pronto are Moore outputs, low in all other states.
- Counters: 4-bit, no wrap is reachable. The timeout counter saturates.
- Button activity in states other than espera is ignored; no pending move is stored.
- jogar held high through an end state restarts only once; preparacao does not re-check jogar.

Optional Feature:
- TIMEOUT_EN defined: timeout logic as specified above.
- TIMEOUT_EN undefined:
  - Timeout counter removed.
  - espera waits indefinitely.
  - fim_timeout unreachable.
  - db_timeout tied to 0.

Test Plan:
- Reset pulse, then idle 15 cycles -> db_estado=0; ganhou=perdeu=pronto=0; leds=0000.
- jogar=1 for 5 cycles, then press ROM entries 0..r for r=0..15 (10 cycles held, 10 released each) -> after the final press: state A, ganhou=1, pronto=1, perdeu=0, db_sequencia shows F.
- After a win, jogar=1, press 0001 then wait 10000 cycles -> advances to round 1, then after TIMEOUT_CYCLES: state D, perdeu=1, pronto=1, db_timeout=1.
- Start game, round 0 press 0010 (expected 0001) -> state E, perdeu=1, pronto=1, db_igual=0.
- Hold 0001 for 20 cycles in espera -> db_tem_jogada pulses exactly once; a single comparison occurs.
- Assert reset mid-game (state 3) -> immediate return to state 0; all counters 0 without waiting for a clock edge.
